// File: rtl/exe_trig_cordic_pkg.sv
// rtl/exe_trig_cordic_pkg.sv - shared constants, state enum and arctangent table for the trig unit
package exe_trig_cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_DONE
    } trig_state_e;

    // Q16.16 constants; CORDIC_K pre-scales x so the gain of the rotations cancels out
    localparam int CORDIC_K = 39797;
    localparam int PI       = 205887;
    localparam int HALF_PI  = 102944;

    function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
        logic signed [31:0] v;
        case (idx)
            5'd0:    v = 32'sd51472;
            5'd1:    v = 32'sd30386;
            5'd2:    v = 32'sd16055;
            5'd3:    v = 32'sd8150;
            5'd4:    v = 32'sd4091;
            5'd5:    v = 32'sd2047;
            5'd6:    v = 32'sd1024;
            5'd7:    v = 32'sd512;
            5'd8:    v = 32'sd256;
            5'd9:    v = 32'sd128;
            5'd10:   v = 32'sd64;
            5'd11:   v = 32'sd32;
            5'd12:   v = 32'sd16;
            5'd13:   v = 32'sd8;
            5'd14:   v = 32'sd4;
            5'd15:   v = 32'sd2;
            default: v = 32'sd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/exe_trig_cordic_iter.sv
// rtl/exe_trig_cordic_iter.sv - one combinational CORDIC micro-rotation in rotation mode
module exe_trig_cordic_iter
    import exe_trig_cordic_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int XY_W   = DATA_W + 2
) (
    input  logic signed [XY_W-1:0]   x_i,
    input  logic signed [XY_W-1:0]   y_i,
    input  logic signed [DATA_W-1:0] z_i,
    input  logic        [4:0]        iter_i,
    output logic signed [XY_W-1:0]   x_o,
    output logic signed [XY_W-1:0]   y_o,
    output logic signed [DATA_W-1:0] z_o
);

    logic signed [XY_W-1:0]   x_sh;
    logic signed [XY_W-1:0]   y_sh;
    logic signed [DATA_W-1:0] atan_v;

    always_comb begin
        x_sh   = x_i >>> iter_i;
        y_sh   = y_i >>> iter_i;
        atan_v = DATA_W'(atan_lut(iter_i));
        // zero residual angle rotates in the positive direction
        if (z_i >= 0) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_v;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_v;
        end
    end

endmodule

// File: rtl/exe_trig_cordic.sv
// rtl/exe_trig_cordic.sv - multi-cycle sine/cosine execute unit with pipeline stall and flush
module exe_trig_cordic
    import exe_trig_cordic_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int ITER   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              trig_sel_i,
    input  logic [DATA_W-1:0] angle_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              range_err_o
);

    localparam int XY_W = DATA_W + 2;
    localparam logic [4:0] LAST_I = 5'(ITER - 1);
    localparam logic signed [DATA_W-1:0] PI_V      = DATA_W'(PI);
    localparam logic signed [DATA_W-1:0] HALF_PI_V = DATA_W'(HALF_PI);
    localparam logic signed [XY_W-1:0]   SAT_P     = XY_W'(longint'(1) << FRAC_W);
    localparam logic signed [XY_W-1:0]   SAT_N     = -SAT_P;

    trig_state_e              state_q, state_d;
    logic                     sel_q, sel_d;
    logic signed [DATA_W-1:0] angle_q, angle_d;
    logic signed [XY_W-1:0]   x_q, x_d;
    logic signed [XY_W-1:0]   y_q, y_d;
    logic signed [DATA_W-1:0] z_q, z_d;
    logic        [4:0]        i_q, i_d;
    logic                     neg_q, neg_d;
    logic                     rerr_q, rerr_d;
    logic signed [DATA_W-1:0] result_q, result_d;

    logic signed [XY_W-1:0]   x_nxt, y_nxt;
    logic signed [DATA_W-1:0] z_nxt;
    logic signed [XY_W-1:0]   res_pre;
    logic signed [DATA_W-1:0] res_sat;
    logic                     idle_like;

    exe_trig_cordic_iter #(
        .DATA_W (DATA_W),
        .XY_W   (XY_W)
    ) u_iter (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .iter_i (i_q),
        .x_o    (x_nxt),
        .y_o    (y_nxt),
        .z_o    (z_nxt)
    );

    // final rotation result, undone quadrant fold, clamped to +/-1.0
    always_comb begin
        res_pre = sel_q ? x_nxt : y_nxt;
        if (neg_q) begin
            res_pre = -res_pre;
        end
        if (res_pre > SAT_P) begin
            res_sat = DATA_W'(SAT_P);
        end else if (res_pre < SAT_N) begin
            res_sat = DATA_W'(SAT_N);
        end else begin
            res_sat = DATA_W'(res_pre);
        end
    end

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        angle_d  = angle_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        i_d      = i_q;
        neg_d    = neg_q;
        rerr_d   = rerr_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        sel_d   = trig_sel_i;
                        angle_d = angle_i;
                        state_d = ST_PREP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREP: begin
                    if (angle_q > HALF_PI_V) begin
                        z_d   = angle_q - PI_V;
                        neg_d = 1'b1;
                    end else if (angle_q < -HALF_PI_V) begin
                        z_d   = angle_q + PI_V;
                        neg_d = 1'b1;
                    end else begin
                        z_d   = angle_q;
                        neg_d = 1'b0;
                    end
                    x_d     = XY_W'(CORDIC_K);
                    y_d     = '0;
                    i_d     = '0;
                    rerr_d  = (angle_q > PI_V) || (angle_q < -PI_V);
                    state_d = ST_ITER;
                end
                ST_ITER: begin
                    x_d = x_nxt;
                    y_d = y_nxt;
                    z_d = z_nxt;
                    i_d = i_q + 5'd1;
                    if (i_q == LAST_I) begin
                        result_d = res_sat;
                        state_d  = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            angle_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            i_q      <= '0;
            neg_q    <= 1'b0;
            rerr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            angle_q  <= angle_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            i_q      <= i_d;
            neg_q    <= neg_d;
            rerr_q   <= rerr_d;
            result_q <= result_d;
        end
    end

    // drops in the DONE cycle so the pipeline advances together with the result
    assign stall_o     = !flush_i && ((state_q == ST_PREP) || (state_q == ST_ITER) ||
                                      (idle_like && start_i));
    assign done_o      = (state_q == ST_DONE) && !flush_i;
    assign range_err_o = done_o && rerr_q;
    assign result_o    = result_q;

endmodule
